// File: rtl/conv_viterbi_codec.sv
// Rate-1/2, K=3 convolutional encoder (g=111,101) and an independent 4-state
// hard-decision Viterbi decoder using register-exchange survivors.
module conv_viterbi_codec #(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_in,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_out,
    input  logic       dec_enable,
    input  logic [1:0] dec_d_in,
    output logic       dec_d_out
);

    function automatic logic [1:0] hamming(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] z;
        z = x ^ y;
        return {1'b0, z[1]} + {1'b0, z[0]};
    endfunction

    // ---------------- encoder ----------------
    logic       s1_q, s1_d, s0_q, s0_d;
    logic [1:0] enc_out_q, enc_out_d;
    logic       enc_valid_q, enc_valid_d;

    always_comb begin
        s1_d        = s1_q;
        s0_d        = s0_q;
        enc_out_d   = enc_out_q;
        enc_valid_d = enc_enable_i;
        if (enc_enable_i) begin
            enc_out_d = {enc_d_in ^ s1_q ^ s0_q, enc_d_in ^ s0_q};
            s1_d      = enc_d_in;
            s0_d      = s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= 1'b0;
            s0_q        <= 1'b0;
            enc_out_q   <= '0;
            enc_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            enc_out_q   <= enc_out_d;
            enc_valid_q <= enc_valid_d;
        end
    end

    assign enc_d_out   = enc_out_q;
    assign enc_valid_o = enc_valid_q;

    // ---------------- decoder ----------------
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic                dec_out_q, dec_out_d;

    logic [PM_W:0]       acs_pm   [4];
    logic [TB_DEPTH-1:0] acs_surv [4];

    // New state {u,a} is reached from predecessors {a,0} and {a,1}.
    for (genvar ns = 0; ns < 4; ns++) begin : g_acs
        localparam int unsigned U  = ns / 2;
        localparam int unsigned A  = ns % 2;
        localparam int unsigned P0 = 2 * A;
        localparam int unsigned P1 = 2 * A + 1;
        localparam logic [1:0] EXP0 = 2'(((U ^ A) * 2) + U);
        localparam logic [1:0] EXP1 = 2'(((U ^ A ^ 1) * 2) + (U ^ 1));

        logic [PM_W:0]       sum0, sum1;
        logic                take1;
        logic [TB_DEPTH-1:0] pred_surv;

        assign sum0      = {1'b0, pm_q[P0]} + {{(PM_W-1){1'b0}}, hamming(dec_d_in, EXP0)};
        assign sum1      = {1'b0, pm_q[P1]} + {{(PM_W-1){1'b0}}, hamming(dec_d_in, EXP1)};
        assign take1     = (sum1 < sum0);
        assign pred_surv = take1 ? surv_q[P1] : surv_q[P0];
        assign acs_pm[ns]   = take1 ? sum1 : sum0;
        assign acs_surv[ns] = {pred_surv[TB_DEPTH-2:0], 1'(U)};
    end

    logic [PM_W:0] min_pm;
    logic [1:0]    min_idx;

    always_comb begin
        min_pm  = acs_pm[0];
        min_idx = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (acs_pm[i] < min_pm) begin
                min_pm  = acs_pm[i];
                min_idx = 2'(i);
            end
        end

        dec_out_d = dec_out_q;
        for (int unsigned i = 0; i < 4; i++) begin
            pm_d[i]   = pm_q[i];
            surv_d[i] = surv_q[i];
        end
        if (dec_enable) begin
            // Normalising to the minimum keeps metrics bounded in PM_W bits.
            for (int unsigned i = 0; i < 4; i++) begin
                pm_d[i]   = PM_W'(acs_pm[i] - min_pm);
                surv_d[i] = acs_surv[i];
            end
            dec_out_d = acs_surv[min_idx][TB_DEPTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_W'(4);
                surv_q[i] <= '0;
            end
            dec_out_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
            dec_out_q <= dec_out_d;
        end
    end

    assign dec_d_out = dec_out_q;

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Loopback bench: encoder -> registered channel (optional bit flips) -> decoder,
// checked against a polynomial encoder model and a full-path Viterbi model.
module tb_conv_viterbi_codec;

    localparam int TBD  = 16;
    localparam int MAXS = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_enable_i, enc_d_in, enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable;
    logic [1:0] dec_d_in;
    logic       dec_d_out;

    always #5 clk = ~clk;

    conv_viterbi_codec #(.TB_DEPTH(TBD), .PM_W(6)) dut (
        .clk(clk), .rst(rst),
        .enc_enable_i(enc_enable_i), .enc_d_in(enc_d_in),
        .enc_valid_o(enc_valid_o), .enc_d_out(enc_d_out),
        .dec_enable(dec_enable), .dec_d_in(dec_d_in), .dec_d_out(dec_d_out)
    );

    // Channel: one register stage with per-symbol flip of bit 0.
    logic [1:0] ch_sym;
    logic       ch_vld;
    int         chan_cnt;
    bit         flip_tab [MAXS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_sym   <= '0;
            ch_vld   <= 1'b0;
            chan_cnt <= 0;
        end else begin
            ch_vld <= enc_valid_o;
            if (enc_valid_o) begin
                ch_sym   <= enc_d_out ^ {1'b0, flip_tab[chan_cnt]};
                chan_cnt <= chan_cnt + 1;
            end
        end
    end

    assign dec_d_in   = ch_sym;
    assign dec_enable = ch_vld;

    int n_cmp, n_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    logic [1:0] exp_enc_out;
    logic       exp_enc_valid;
    logic       exp_dec;
    int         pm [4];
    bit         path  [4][MAXS];
    bit         npath [4][MAXS];
    int         dm;
    bit         enc_bits [$];
    bit         in_bits [$];
    bit         dec_log [$];
    bit         clean_log [$];
    logic [1:0] enc_log [$];
    bit         pend_dec;
    int         pend_idx;
    int         dec_bit_err;
    bit         stim [MAXS];

    task automatic model_reset();
        exp_enc_out   = '0;
        exp_enc_valid = 1'b0;
        exp_dec       = 1'b0;
        pm = '{0, 4, 4, 4};
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < MAXS; j++) path[s][j] = 1'b0;
        dm = 0;
        enc_bits.delete();
        in_bits.delete();
        dec_log.delete();
        enc_log.delete();
        pend_dec    = 1'b0;
        pend_idx    = 0;
        dec_bit_err = 0;
    endtask

    function automatic bit bitat(input int i);
        return (i < 0) ? 1'b0 : enc_bits[i];
    endfunction

    // Unnormalised integer metrics and complete per-state decision histories.
    task automatic dec_model_step(input logic [1:0] r);
        int npm [4];
        int c, best, bp, mn, k, u, a, p, e1, e0;
        for (int ns = 0; ns < 4; ns++) begin
            u = ns / 2;
            a = ns % 2;
            best = 0;
            bp = 0;
            for (int b = 0; b < 2; b++) begin
                p  = 2 * a + b;
                e1 = u ^ a ^ b;
                e0 = u ^ b;
                c  = pm[p] + (int'(r[1]) ^ e1) + (int'(r[0]) ^ e0);
                if (b == 0 || c < best) begin
                    best = c;
                    bp   = p;
                end
            end
            npm[ns] = best;
            for (int j = 0; j < dm; j++) npath[ns][j] = path[bp][j];
            npath[ns][dm] = bit'(u);
        end
        for (int s = 0; s < 4; s++) begin
            pm[s] = npm[s];
            for (int j = 0; j <= dm; j++) path[s][j] = npath[s][j];
        end
        mn = 0;
        for (int s = 1; s < 4; s++) if (pm[s] < pm[mn]) mn = s;
        k = dm - (TBD - 1);
        exp_dec  = (k >= 0) ? path[mn][k] : 1'b0;
        pend_idx = dm;
        dm++;
    endtask

    task automatic do_checks();
        int k;
        check("enc_valid", enc_valid_o, exp_enc_valid);
        check("enc_d_out", enc_d_out, exp_enc_out);
        check("dec_d_out", dec_d_out, exp_dec);
        if (exp_enc_valid) enc_log.push_back(enc_d_out);
        if (pend_dec) begin
            dec_log.push_back(dec_d_out);
            k = pend_idx - (TBD - 1);
            if (k >= 0 && k < in_bits.size() && dec_d_out != in_bits[k]) dec_bit_err++;
        end
    endtask

    task automatic step(input bit en, input bit d);
        int n;
        @(negedge clk);
        do_checks();
        pend_dec = dec_enable;
        if (dec_enable) dec_model_step(dec_d_in);
        enc_enable_i  = en;
        enc_d_in      = d;
        exp_enc_valid = en;
        if (en) begin
            enc_bits.push_back(d);
            in_bits.push_back(d);
            n = enc_bits.size();
            exp_enc_out = {d ^ bitat(n - 2) ^ bitat(n - 3), d ^ bitat(n - 3)};
        end
    endtask

    task automatic flush();
        repeat (4) step(1'b0, 1'b0);
    endtask

    task automatic run(input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = 0;
                while (g < 3 && $urandom_range(0, 3) == 0) begin
                    step(1'b0, 1'b0);
                    g++;
                end
            end
            step(1'b1, stim[i]);
        end
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        enc_enable_i = 1'b0;
        enc_d_in     = 1'b0;
        #1;
        check("rst_enc_valid", enc_valid_o, 0);
        check("rst_enc_d_out", enc_d_out, 0);
        check("rst_dec_d_out", dec_d_out, 0);
        model_reset();
        for (int i = 0; i < MAXS; i++) flip_tab[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic new_stim();
        for (int i = 0; i < MAXS; i++) stim[i] = bit'($urandom_range(0, 1));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs, injected;
        logic [1:0] enc_ref [4];
        n_cmp = 0;
        n_mis = 0;
        enc_enable_i = 1'b0;
        enc_d_in     = 1'b0;
        model_reset();

        // Encoder directed sequence 1,0,1,1 from reset.
        apply_reset();
        stim[0] = 1'b1; stim[1] = 1'b0; stim[2] = 1'b1; stim[3] = 1'b1;
        run(4, 1'b0);
        flush();
        enc_ref = '{2'b11, 2'b10, 2'b00, 2'b01};
        check("enc_seq_len", enc_log.size(), 4);
        for (int i = 0; i < 4 && i < enc_log.size(); i++) check("enc_seq", enc_log[i], enc_ref[i]);

        // Clean loopback.
        apply_reset();
        new_stim();
        run(256, 1'b0);
        flush();
        check("clean_bit_err", dec_bit_err, 0);
        check("clean_dec_count", dec_log.size(), 256);
        clean_log = dec_log;

        // Same bits with random enable gaps.
        apply_reset();
        run(256, 1'b1);
        flush();
        check("gap_bit_err", dec_bit_err, 0);
        check("gap_dec_count", dec_log.size(), clean_log.size());
        diffs = 0;
        for (int i = 0; i < dec_log.size() && i < clean_log.size(); i++)
            if (dec_log[i] != clean_log[i]) diffs++;
        check("gap_vs_nogap", diffs, 0);

        // Sparse errors: one flip every 16th symbol.
        apply_reset();
        new_stim();
        for (int i = 0; i < 256; i++) flip_tab[i] = (i % 16 == 15);
        run(256, 1'b0);
        flush();
        check("sparse_bit_err", dec_bit_err, 0);

        // Random errors, probability 2/16 per symbol.
        apply_reset();
        new_stim();
        injected = 0;
        for (int i = 0; i < 256; i++) begin
            flip_tab[i] = ($urandom_range(0, 15) < 2);
            if (flip_tab[i]) injected++;
        end
        run(256, 1'b0);
        flush();
        $display("random channel: injected %0d bad bits, %0d decoded mismatches over %0d bits",
                 injected, dec_bit_err, 256 - (TBD - 1));

        // Reset at symbol 100, then a fresh stream.
        apply_reset();
        new_stim();
        run(101, 1'b0);
        apply_reset();
        new_stim();
        run(128, 1'b0);
        flush();
        check("post_reset_bit_err", dec_bit_err, 0);
        check("post_reset_dec_count", dec_log.size(), 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
